// File: rtl/jtframe_mailbox.sv
// jtframe_mailbox: bidirectional main/sound CPU mailbox with NMI gating and overflow flags
module jtframe_mailbox_fifo #(
  parameter int DW = 8,
  parameter int AW = 2,
  parameter int LATCH = 0,
  parameter logic [DW-1:0] EMPTY_VAL = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          wr,
  input  logic          rd,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   cnt,
  output logic          ovf_ev
);
  localparam int IW = AW > 0 ? AW : 1;
  localparam logic [AW:0] MSB = (AW+1)'(1) << AW;
  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wptr, rptr, wlast;
  logic [IW-1:0] wa, ra, la;
  logic          push, pop;
  assign wlast  = wptr - (AW+1)'(1);
  assign wa     = AW == 0 ? '0 : IW'(wptr);
  assign ra     = AW == 0 ? '0 : IW'(rptr);
  assign la     = AW == 0 ? '0 : IW'(wlast);
  assign empty  = wptr == rptr;
  assign full   = (wptr ^ rptr) == MSB;
  assign cnt    = wptr - rptr;
  assign push   = wr & (~full | rd);
  assign pop    = rd & ~empty;
  assign ovf_ev = wr & full & ~rd;
  assign dout   = empty ? EMPTY_VAL : mem[ra];
  // pointer update; a pop on a full FIFO frees the slot the concurrent push takes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
    end
  // storage, unreset; in latch mode an overflowing write replaces the newest entry
  always_ff @(posedge clk)
    if (push) mem[wa] <= din;
    else if (ovf_ev && LATCH != 0) mem[la] <= din;
endmodule

module jtframe_mailbox #(
  parameter int DW = 8,
  parameter int AW = 2,
  parameter int LATCH = 0,
  parameter logic [DW-1:0] EMPTY_VAL = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] main_din,
  input  logic          main_wr,
  input  logic          main_rd,
  output logic [DW-1:0] main_dout,
  output logic          main_empty,
  output logic          main_full,
  input  logic [DW-1:0] snd_din,
  input  logic          snd_wr,
  input  logic          snd_rd,
  output logic [DW-1:0] snd_dout,
  output logic          snd_empty,
  output logic          snd_full,
  output logic [AW:0]   m2s_cnt,
  output logic [AW:0]   s2m_cnt,
  input  logic          nmi_set,
  input  logic          nmi_clr,
  output logic          nmi_n,
  output logic [1:0]    ovf,
  input  logic          ovf_clr
);
  logic m2s_ev, s2m_ev, nmi_en;
  jtframe_mailbox_fifo #(.DW(DW), .AW(AW), .LATCH(LATCH), .EMPTY_VAL(EMPTY_VAL)) u_m2s (
    .clk(clk), .rst(rst), .din(main_din), .wr(main_wr), .rd(snd_rd), .dout(snd_dout),
    .empty(snd_empty), .full(main_full), .cnt(m2s_cnt), .ovf_ev(m2s_ev)
  );
  jtframe_mailbox_fifo #(.DW(DW), .AW(AW), .LATCH(LATCH), .EMPTY_VAL(EMPTY_VAL)) u_s2m (
    .clk(clk), .rst(rst), .din(snd_din), .wr(snd_wr), .rd(main_rd), .dout(main_dout),
    .empty(main_empty), .full(snd_full), .cnt(s2m_cnt), .ovf_ev(s2m_ev)
  );
  // sticky overflow flags, a fresh overflow beats a clear; NMI enable where clear beats set
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ovf    <= 2'b00;
      nmi_en <= 1'b0;
      nmi_n  <= 1'b1;
    end else begin
      ovf    <= (ovf & {2{~ovf_clr}}) | {s2m_ev, m2s_ev};
      nmi_en <= ~nmi_clr & (nmi_set | nmi_en);
      nmi_n  <= ~(nmi_en & ~snd_empty);
    end
endmodule

// File: tb/tb_jtframe_mailbox.sv
// tb_jtframe_mailbox: directed checks of the mailbox plus an s2m scoreboard run
module tb_jtframe_mailbox;
  logic       clk = 0, rst = 1;
  logic [7:0] main_din = 0, snd_din = 0;
  logic       main_wr = 0, main_rd = 0, snd_wr = 0, snd_rd = 0;
  logic       nmi_set = 0, nmi_clr = 0, ovf_clr = 0;
  logic [7:0] main_dout, snd_dout, l_main_dout, l_snd_dout;
  logic       main_empty, main_full, snd_empty, snd_full, nmi_n;
  logic       l_main_empty, l_main_full, l_snd_empty, l_snd_full, l_nmi_n;
  logic [2:0] m2s_cnt, s2m_cnt;
  logic [0:0] l_m2s_cnt, l_s2m_cnt;
  logic [1:0] ovf, l_ovf;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] q[$];
  logic [7:0] vals[4];
  logic       ex_ovf, pushok, popok, ovev, full_m;
  logic [2:0] ex_m2s;

  always #5 clk = ~clk;

  jtframe_mailbox u0 (
    .clk(clk), .rst(rst), .main_din(main_din), .main_wr(main_wr), .main_rd(main_rd),
    .main_dout(main_dout), .main_empty(main_empty), .main_full(main_full),
    .snd_din(snd_din), .snd_wr(snd_wr), .snd_rd(snd_rd), .snd_dout(snd_dout),
    .snd_empty(snd_empty), .snd_full(snd_full), .m2s_cnt(m2s_cnt), .s2m_cnt(s2m_cnt),
    .nmi_set(nmi_set), .nmi_clr(nmi_clr), .nmi_n(nmi_n), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  jtframe_mailbox #(.AW(0), .LATCH(1)) u1 (
    .clk(clk), .rst(rst), .main_din(main_din), .main_wr(main_wr), .main_rd(main_rd),
    .main_dout(l_main_dout), .main_empty(l_main_empty), .main_full(l_main_full),
    .snd_din(snd_din), .snd_wr(snd_wr), .snd_rd(snd_rd), .snd_dout(l_snd_dout),
    .snd_empty(l_snd_empty), .snd_full(l_snd_full), .m2s_cnt(l_m2s_cnt), .s2m_cnt(l_s2m_cnt),
    .nmi_set(nmi_set), .nmi_clr(nmi_clr), .nmi_n(l_nmi_n), .ovf(l_ovf), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    main_din = v;
    main_wr = 1;
    tick();
    main_wr = 0;
  endtask

  task automatic pop;
    snd_rd = 1;
    tick();
    snd_rd = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    rst = 0;
    tick();
    chk("rst_snd_dout", snd_dout, 8'hFF);
    chk("rst_main_dout", main_dout, 8'hFF);
    chk("rst_snd_empty", snd_empty, 1);
    chk("rst_main_empty", main_empty, 1);
    chk("rst_main_full", main_full, 0);
    chk("rst_snd_full", snd_full, 0);
    chk("rst_nmi_n", nmi_n, 1);
    chk("rst_ovf", ovf, 0);
    chk("rst_l_snd_dout", l_snd_dout, 8'hFF);
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (vals[i]) push(vals[i]);
    chk("fill_cnt", m2s_cnt, 4);
    chk("fill_full", main_full, 1);
    chk("fill_head", snd_dout, 8'h11);
    chk("fill_ovf", ovf, 0);
    push(8'h55);
    chk("ovf_set", ovf, 2'b01);
    chk("ovf_cnt", m2s_cnt, 4);
    foreach (vals[i]) begin
      chk("pop_data", snd_dout, vals[i]);
      pop();
    end
    chk("drain_dout", snd_dout, 8'hFF);
    chk("drain_empty", snd_empty, 1);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ovf_clr", ovf, 0);
    vals = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (vals[i]) push(vals[i]);
    main_din = 8'h99;
    main_wr = 1;
    snd_rd = 1;
    tick();
    main_wr = 0;
    snd_rd = 0;
    chk("full_rw_ovf", ovf, 0);
    chk("full_rw_cnt", m2s_cnt, 4);
    vals = '{8'h02, 8'h03, 8'h04, 8'h99};
    foreach (vals[i]) begin
      chk("full_rw_data", snd_dout, vals[i]);
      pop();
    end
    chk("full_rw_empty", snd_empty, 1);
    pop();
    chk("pop_empty_cnt", m2s_cnt, 0);
    chk("pop_empty_ovf", ovf, 0);
    main_din = 8'h77;
    main_wr = 1;
    snd_rd = 1;
    tick();
    main_wr = 0;
    snd_rd = 0;
    chk("empty_rw_cnt", m2s_cnt, 1);
    chk("empty_rw_data", snd_dout, 8'h77);
    pop();
    nmi_set = 1;
    tick();
    nmi_set = 0;
    push(8'hA5);
    chk("nmi_pre", nmi_n, 1);
    tick();
    chk("nmi_low", nmi_n, 0);
    pop();
    chk("nmi_hold", nmi_n, 0);
    tick();
    chk("nmi_release", nmi_n, 1);
    nmi_set = 1;
    nmi_clr = 1;
    tick();
    nmi_set = 0;
    nmi_clr = 0;
    push(8'h3C);
    tick();
    tick();
    chk("nmi_clr_wins", nmi_n, 1);
    pop();
    do_reset();
    push(8'h01);
    push(8'h02);
    chk("latch_dout", l_snd_dout, 8'h02);
    chk("latch_ovf", l_ovf[0], 1);
    chk("latch_cnt", l_m2s_cnt, 1);
    chk("latch_empty", l_snd_empty, 0);
    ovf_clr = 1;
    push(8'h03);
    ovf_clr = 0;
    chk("latch_clr_set", l_ovf[0], 1);
    chk("latch_dout2", l_snd_dout, 8'h03);
    chk("wide_clr", ovf, 0);
    chk("wide_cnt", m2s_cnt, 3);
    do_reset();
    nmi_set = 1;
    tick();
    nmi_set = 0;
    push(8'h5A);
    tick();
    chk("sb_nmi", nmi_n, 0);
    ex_ovf = 0;
    ex_m2s = 1;
    for (int i = 0; i < 2000; i++) begin
      snd_wr = $urandom_range(0, 9) < (i < 1000 ? 7 : 4);
      main_rd = $urandom_range(0, 9) < (i < 1000 ? 3 : 6);
      snd_din = 8'($urandom);
      full_m = q.size() == 4;
      pushok = snd_wr & (~full_m | main_rd);
      popok = main_rd & (q.size() != 0);
      ovev = snd_wr & full_m & ~main_rd;
      tick();
      if (popok) void'(q.pop_front());
      if (pushok) q.push_back(snd_din);
      ex_ovf |= ovev;
      chk("sb_dout", main_dout, q.size() != 0 ? q[0] : 8'hFF);
      chk("sb_cnt", s2m_cnt, q.size());
      chk("sb_full", snd_full, q.size() == 4);
      chk("sb_ovf", ovf, {ex_ovf, 1'b0});
      chk("sb_m2s_cnt", m2s_cnt, ex_m2s);
      chk("sb_m2s_dout", snd_dout, ex_m2s != 0 ? 8'h5A : 8'hFF);
      if (i == 1200) begin
        #2 rst = 1;
        #1;
        chk("mid_rst_empty", main_empty, 1);
        chk("mid_rst_cnt", s2m_cnt, 0);
        chk("mid_rst_m2s", snd_empty, 1);
        chk("mid_rst_nmi", nmi_n, 1);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_dout", main_dout, 8'hFF);
        #1 rst = 0;
        q.delete();
        ex_ovf = 0;
        ex_m2s = 0;
      end
    end
    snd_wr = 0;
    main_rd = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtframe_mailbox.md
Name: jtframe_mailbox

Overview:
- Parametrised bidirectional CPU-to-CPU mailbox. Replaces the single-byte sound latch, strobe and flag pair between the main and sound CPUs.
- Two independent FIFOs: main→snd (m2s) and snd→main (s2m).
- Each FIFO has configurable width and depth, plus an optional overwrite (latch) mode.
- Generates a gated NMI request to the sound CPU and sticky overflow flags. Sits between the main CPU bus decoder and the sound CPU I/O decoder, all in the clk domain.

Parameters:
DW, 8, data width of both FIFOs
AW, 2, log2 FIFO depth (depth = 2**AW); AW=0 gives a single-entry latch
LATCH, 0, 1 = a write to a full FIFO overwrites the newest entry instead of being dropped
EMPTY_VAL, all ones ({DW{1'b1}}), value driven on a dout port while its FIFO is empty

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
main_din  in  DW  data written into m2s
main_wr  in  1  single-cycle push strobe into m2s
main_rd  in  1  single-cycle pop strobe from s2m
main_dout  out  DW  head of s2m (show-ahead)
main_empty  out  1  s2m empty
main_full  out  1  m2s full
snd_din  in  DW  data written into s2m
snd_wr  in  1  single-cycle push strobe into s2m
snd_rd  in  1  single-cycle pop strobe from m2s
snd_dout  out  DW  head of m2s (show-ahead)
snd_empty  out  1  m2s empty
snd_full  out  1  s2m full
m2s_cnt  out  AW+1  m2s occupancy
s2m_cnt  out  AW+1  s2m occupancy
nmi_set  in  1  sound CPU enables NMI
nmi_clr  in  1  sound CPU disables NMI
nmi_n  out  1  NMI request to sound CPU, active low
ovf  out  2  sticky overflow flags {s2m, m2s}
ovf_clr  in  1  clears both overflow flags

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - Pointers and counts 0, so both FIFOs are empty.
  - *_empty=1, *_full=0, *_dout=EMPTY_VAL.
  - nmi_en=0, nmi_n=1, ovf=2'b00.
  - Storage contents need not be reset.
- FIFO structure:
  - Register array of 2**AW entries.
  - Read and write pointers are AW+1 bits and wrap modulo 2**(AW+1).
  - empty = (wptr == rptr).
  - full = (MSBs differ and the low AW bits are equal).
  - cnt = wptr − rptr.
- Push: on the wr strobe when not full, store din at wptr[AW-1:0] and increment wptr. The new data is visible on the far-side dout the next cycle.
- Pop: on the rd strobe when not empty, increment rptr. dout shows the next entry, or EMPTY_VAL, the next cycle.
- dout is always the entry at rptr. It is a combinational read of the registers, with no read latency.
- Pop when empty: ignored. No pointer change, no flag.
- Push when full, LATCH=0: data dropped; the direction's ovf bit sets the next cycle.
- Push when full, LATCH=1: the newest entry (wptr−1) is overwritten; pointers unchanged; ovf bit is still set.
- Simultaneous push and pop:
  - Not empty and not full: both performed, count unchanged.
  - Full: the pop frees a slot and the push is accepted. No overflow; count unchanged.
  - Empty: push accepted, pop ignored (no bypass). Count becomes 1.
- Both FIFOs are fully independent. Activity on one never stalls the other.
- ovf:
  - Sticky.
  - ovf_clr clears both bits.
  - ovf_clr in the same cycle as a new overflow: the set wins.
- nmi_en:
  - nmi_set → 1, nmi_clr → 0.
  - Both asserted together: clr wins.
- nmi_n is registered: nmi_n <= ~(nmi_en & ~snd_empty).
  - It asserts one cycle after the first push into m2s while enabled.
  - It releases one cycle after the pop that empties m2s, or after nmi_clr.
- AW=0, LATCH=1 is the legacy configuration: single latch, last write wins, snd_empty behaves as the inverted sound flag.
- Reset mid-operation: both FIFOs are flushed immediately. No partial push or pop is retained.

Test Plan:
- Reset, then check idle state → snd_dout=main_dout=8'hFF, both empty=1, both full=0, nmi_n=1, ovf=0.
- AW=2: push 8'h11, 8'h22, 8'h33, 8'h44 via main_wr → m2s_cnt=4, main_full=1. A 5th push of 8'h55 → ovf=2'b01, data dropped. Four snd_rd pops → snd_dout reads 11, 22, 33, 44, then FF.
- Full m2s with snd_rd and main_wr in the same cycle (din 8'h99) → no overflow, cnt stays 4; 8'h99 pops last.
- nmi_set, then main_wr 8'hA5 → nmi_n low one cycle later. snd_rd → nmi_n high one cycle later. nmi_set and nmi_clr together → nmi_en=0 and nmi_n stays high on a new push.
- AW=0, LATCH=1: main_wr 8'h01 then 8'h02 → snd_dout=8'h02, ovf[0]=1. ovf_clr with a simultaneous overflowing push → ovf[0] remains 1.
- Interleaved snd_wr/main_rd traffic over 2000 cycles, with rst asserted mid-stream → scoreboard matches with no crosstalk into m2s. rst asynchronously empties both FIFOs and forces nmi_n=1.
